// File: rtl/ros2_sub_msg_reader.sv
// Mirrors ros2_ether subscriber app-data writes locally and replays each received message as a byte stream.
// Optional ROS2_SUB_READER_NUL_STRIP_EN drops a trailing NUL byte from the streamed message.
module ros2_sub_msg_reader #(
  parameter int MAX_LEN = 64,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-1:0] sub_addr,
  input  logic          sub_ce,
  input  logic          sub_we,
  input  logic [7:0]    sub_wdata,
  input  logic [7:0]    sub_len,
  input  logic          sub_recv,
  output logic          sub_req,
  output logic          sub_rel,
  input  logic          sub_grant,
  output logic [7:0]    m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic [7:0]    msg_len,
  output logic          busy,
  output logic [15:0]   drop_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, READ, REL} state_t;

  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  state_t        state_reg, state_next;
  logic [7:0]    buf_mem [MAX_LEN];
  logic [AW-1:0] idx_reg, idx_next;
  logic [7:0]    len_reg, len_next;
  logic          pending_reg, pending_next;
  logic [15:0]   drop_reg, drop_next, drop_sat;
  logic          tlast_next;
  logic          load_data;
  logic [AW-1:0] rd_addr;
  logic          recv_en;
  logic          hs;
  logic [7:0]    len_clamp, len_eff;

  assign recv_en   = sub_recv & en;
  assign hs        = m_tvalid & m_tready;
  assign drop_sat  = (drop_reg == 16'hFFFF) ? drop_reg : drop_reg + 16'd1;
  assign len_clamp = ({1'b0, sub_len} > MAX_LEN_W) ? MAX_LEN_W[7:0] : sub_len;

`ifdef ROS2_SUB_READER_NUL_STRIP_EN
  logic [AW-1:0] tail_addr;
  assign tail_addr = AW'(len_clamp - 8'd1);
  assign len_eff   = (len_clamp != 8'd0 && buf_mem[tail_addr] == 8'h00) ? len_clamp - 8'd1 : len_clamp;
`else
  assign len_eff   = len_clamp;
`endif

  // Write side is never blocked: the writer owns ordering against our grant.
  always_ff @(posedge clk) begin
    if (sub_ce && sub_we && (32'(sub_addr) < MAX_LEN))
      buf_mem[sub_addr] <= sub_wdata;
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    len_next     = len_reg;
    pending_next = pending_reg;
    drop_next    = drop_reg;
    tlast_next   = m_tlast;
    load_data    = 1'b0;
    rd_addr      = idx_reg;
    case (state_reg)
      IDLE: begin
        if (recv_en) state_next = REQ;
      end
      REQ, READ: begin
        if (recv_en) begin
          if (pending_reg) drop_next = drop_sat;
          else             pending_next = 1'b1;
        end
        if (state_reg == REQ) begin
          if (sub_grant) begin
            len_next   = len_eff;
            idx_next   = '0;
            rd_addr    = '0;
            load_data  = 1'b1;
            tlast_next = (len_eff == 8'd1);
            state_next = (len_eff == 8'd0) ? REL : READ;
          end
        end else if (hs) begin
          if (m_tlast) begin
            tlast_next = 1'b0;
            state_next = REL;
          end else begin
            idx_next   = idx_reg + AW'(1);
            rd_addr    = idx_reg + AW'(1);
            load_data  = 1'b1;
            tlast_next = ((8'(idx_reg) + 8'd1) == (len_reg - 8'd1));
          end
        end
      end
      REL: begin
        // A recv here either becomes the next request or, if one is already queued, is lost.
        if (recv_en && pending_reg) drop_next = drop_sat;
        pending_next = 1'b0;
        state_next   = (pending_reg || recv_en) ? REQ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      len_reg     <= '0;
      pending_reg <= 1'b0;
      drop_reg    <= '0;
      sub_req     <= 1'b0;
      sub_rel     <= 1'b0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      m_tdata     <= '0;
      busy        <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      len_reg     <= len_next;
      pending_reg <= pending_next;
      drop_reg    <= drop_next;
      sub_req     <= (state_next == REQ) || (state_next == READ);
      sub_rel     <= (state_next == REL);
      m_tvalid    <= (state_next == READ);
      m_tlast     <= tlast_next;
      busy        <= (state_next != IDLE);
      if (load_data) m_tdata <= buf_mem[rd_addr];
    end
  end

  assign msg_len  = len_reg;
  assign drop_cnt = drop_reg;

endmodule
